ela_seq_ctrl: RTL and testbench

- Control sequencer for the ELA (edge-based line average) datapath.
- Fetches one 16-pixel row at a time from the host via a req pulse and steers pixels into two ping-pong line buffers.
- Schedules output order: original row 0, then interpolated row and original row for each further input row.
- Drives datapath read addresses, output mux select and valid, producing 9 output rows from 5 input rows. Pixel arithmetic lives in the datapath, not here.

---
 rtl/ela_pkg.sv | 26 ++
 rtl/ela_delay_line.sv | 38 +++
 rtl/ela_seq_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_ela_seq_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ela_pkg.sv
// Shared types and constants for the ELA sequencer.
package ela_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_GAP    = 3'd2,
        ST_LOAD   = 3'd3,
        ST_EMIT_I = 3'd4,
        ST_EMIT_O = 3'd5,
        ST_DRAIN  = 3'd6,
        ST_DONE   = 3'd7
    } ela_state_e;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_IN_ROWS = 5;
    localparam int DEF_RD_LAT  = 1;
    localparam int COL_W       = $clog2(DEF_WIDTH);
    localparam int OUT_ROWS    = 2 * DEF_IN_ROWS - 1;

    // True in the two states that issue read addresses to the datapath.
    function automatic logic is_emit(input ela_state_e s);
        return (s == ST_EMIT_I) || (s == ST_EMIT_O);
    endfunction

endpackage

// File: rtl/ela_delay_line.sv
// Fixed-depth shift register carrying {issue, sel} from the read-address
// stage to the point where datapath output data is available.
module ela_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic [1:0] i_din,
    output logic [1:0] o_dout
);

    logic [2*DEPTH-1:0] r_pipe;

    generate
        if (DEPTH == 1) begin : g_single
            // Single stage: capture the input, clear on reset.
            always_ff @(posedge i_clk) begin
                if (i_clr) begin
                    r_pipe <= 2'b00;
                end else begin
                    r_pipe <= i_din;
                end
            end
        end else begin : g_multi
            // Multi stage: newest entry enters at the low end.
            always_ff @(posedge i_clk) begin
                if (i_clr) begin
                    r_pipe <= {(2*DEPTH){1'b0}};
                end else begin
                    r_pipe <= {r_pipe[2*DEPTH-3:0], i_din};
                end
            end
        end
    endgenerate

    assign o_dout = r_pipe[2*DEPTH-1 -: 2];

endmodule

// File: rtl/ela_seq_ctrl.sv
// Control sequencer for the ELA line-average datapath: requests rows from
// the host, steers them into ping-pong line buffers and schedules the
// original / interpolated output rows.
module ela_seq_ctrl
    import ela_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int IN_ROWS = DEF_IN_ROWS,
    parameter int RD_LAT  = DEF_RD_LAT
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    output logic                       o_req,
    output logic                       o_wr_en,
    output logic                       o_wr_buf,
    output logic [$clog2(WIDTH)-1:0]   o_wr_addr,
    output logic                       o_rd_top,
    output logic [$clog2(WIDTH)-1:0]   o_rd_addr,
    output logic                       o_out_sel,
    output logic                       o_valid,
    output logic                       o_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COL_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] DRN_LAST = CW'(RD_LAT - 1);
    localparam logic [2:0]    ROW_LAST = 3'(IN_ROWS - 1);
    localparam logic [2:0]    ROW_MAX  = 3'(IN_ROWS);

    ela_state_e    r_state;
    ela_state_e    w_state_nxt;
    logic [CW-1:0] r_col;
    logic [CW-1:0] w_col_nxt;
    logic [2:0]    r_row;
    logic [2:0]    w_row_nxt;
    logic          r_cur;
    logic          w_cur_nxt;
    logic          w_adv;
    logic          w_col_last;
    logic          w_drain_last;
    logic          w_counting;

    logic          r_req;
    logic          r_wr_en;
    logic          r_wr_buf;
    logic [CW-1:0] r_wr_addr;
    logic          r_rd_top;
    logic [CW-1:0] r_rd_addr;
    logic          r_done;
    logic          w_req_nxt;
    logic          w_wr_en_nxt;
    logic          w_wr_buf_nxt;
    logic [CW-1:0] w_wr_addr_nxt;
    logic          w_rd_top_nxt;
    logic [CW-1:0] w_rd_addr_nxt;
    logic          w_done_nxt;

    logic          w_issue;
    logic          w_sel;
    logic [1:0]    w_dl_out;

    assign w_col_last   = (r_col == COL_LAST);
    assign w_drain_last = (r_col == DRN_LAST);
    assign w_counting   = (r_state == ST_LOAD) || is_emit(r_state) || (r_state == ST_DRAIN);

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; w_adv marks the end of a row's drain.
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        case (r_state)
            ST_IDLE:   w_state_nxt = ST_REQ;
            ST_REQ:    w_state_nxt = ST_GAP;
            ST_GAP:    w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (w_col_last) begin
                    if (r_row == 3'd0) begin
                        w_state_nxt = ST_EMIT_O;
                    end else begin
                        w_state_nxt = ST_EMIT_I;
                    end
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_EMIT_I: begin
                if (w_col_last) begin
                    w_state_nxt = ST_EMIT_O;
                end else begin
                    w_state_nxt = ST_EMIT_I;
                end
            end
            ST_EMIT_O: begin
                if (w_col_last) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_EMIT_O;
                end
            end
            ST_DRAIN: begin
                if (w_drain_last) begin
                    w_adv = 1'b1;
                    if (r_row >= ROW_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE:   w_state_nxt = ST_DONE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Column, row and buffer-pointer next values; column restarts on every state change.
    always_comb begin
        w_col_nxt = COL_ZERO;
        w_row_nxt = r_row;
        w_cur_nxt = r_cur;
        if (w_state_nxt != r_state) begin
            w_col_nxt = COL_ZERO;
        end else if (w_counting) begin
            w_col_nxt = r_col + COL_ONE;
        end else begin
            w_col_nxt = COL_ZERO;
        end
        if (w_adv) begin
            w_cur_nxt = ~r_cur;
            if (r_row == ROW_MAX) begin
                w_row_nxt = r_row;
            end else begin
                w_row_nxt = r_row + 3'd1;
            end
        end else begin
            w_cur_nxt = r_cur;
            w_row_nxt = r_row;
        end
    end

    // Counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col <= COL_ZERO;
            r_row <= 3'd0;
            r_cur <= 1'b0;
        end else begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
            r_cur <= w_cur_nxt;
        end
    end

    // Output decode from the upcoming state so outputs line up with it once registered.
    always_comb begin
        w_req_nxt     = 1'b0;
        w_wr_en_nxt   = 1'b0;
        w_wr_buf_nxt  = 1'b0;
        w_wr_addr_nxt = COL_ZERO;
        w_rd_top_nxt  = 1'b0;
        w_rd_addr_nxt = COL_ZERO;
        w_done_nxt    = 1'b0;
        case (w_state_nxt)
            ST_REQ:  w_req_nxt = 1'b1;
            ST_LOAD: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_buf_nxt  = w_cur_nxt;
                w_wr_addr_nxt = w_col_nxt;
            end
            ST_EMIT_I: begin
                // Upper row of the pair is the previously loaded buffer.
                w_rd_top_nxt  = ~w_cur_nxt;
                w_rd_addr_nxt = w_col_nxt;
            end
            ST_EMIT_O: begin
                w_rd_top_nxt  = w_cur_nxt;
                w_rd_addr_nxt = w_col_nxt;
            end
            ST_DONE: w_done_nxt = 1'b1;
            default: w_req_nxt = 1'b0;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_buf  <= 1'b0;
            r_wr_addr <= COL_ZERO;
            r_rd_top  <= 1'b0;
            r_rd_addr <= COL_ZERO;
            r_done    <= 1'b0;
        end else begin
            r_req     <= w_req_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_buf  <= w_wr_buf_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_rd_top  <= w_rd_top_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Issue/sel are aligned with r_rd_addr, so RD_LAT stages match the datapath read latency.
    assign w_issue = is_emit(r_state);
    assign w_sel   = (r_state == ST_EMIT_I);

    ela_delay_line #(
        .DEPTH (RD_LAT)
    ) u_delay (
        .i_clk  (i_clk),
        .i_clr  (i_rst),
        .i_din  ({w_issue, w_sel}),
        .o_dout (w_dl_out)
    );

    assign o_req     = r_req;
    assign o_wr_en   = r_wr_en;
    assign o_wr_buf  = r_wr_buf;
    assign o_wr_addr = r_wr_addr;
    assign o_rd_top  = r_rd_top;
    assign o_rd_addr = r_rd_addr;
    assign o_valid   = w_dl_out[1];
    assign o_out_sel = w_dl_out[0];
    assign o_done    = r_done;

endmodule

// File: tb/tb_ela_seq_ctrl.sv
// Bench: two sequencers (read latency 1 and 3) driven by a protocol-level
// host and an ELA datapath model; output pixels are compared against a
// golden frame computed directly from the input rows.
module tb_ela_seq_ctrl;
    import ela_pkg::*;

    localparam int W    = DEF_WIDTH;
    localparam int IR   = DEF_IN_ROWS;
    localparam int NOUT = OUT_ROWS * W;
    localparam int CWB  = COL_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           req_s[2], wr_en_s[2], wr_buf_s[2], rd_top_s[2];
    logic           out_sel_s[2], valid_s[2], done_s[2];
    logic [CWB-1:0] wr_addr_s[2], rd_addr_s[2];

    ela_seq_ctrl #(.WIDTH(W), .IN_ROWS(IR), .RD_LAT(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .o_req(req_s[0]), .o_wr_en(wr_en_s[0]),
        .o_wr_buf(wr_buf_s[0]), .o_wr_addr(wr_addr_s[0]), .o_rd_top(rd_top_s[0]),
        .o_rd_addr(rd_addr_s[0]), .o_out_sel(out_sel_s[0]), .o_valid(valid_s[0]),
        .o_done(done_s[0]));

    ela_seq_ctrl #(.WIDTH(W), .IN_ROWS(IR), .RD_LAT(3)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .o_req(req_s[1]), .o_wr_en(wr_en_s[1]),
        .o_wr_buf(wr_buf_s[1]), .o_wr_addr(wr_addr_s[1]), .o_rd_top(rd_top_s[1]),
        .o_rd_addr(rd_addr_s[1]), .o_out_sel(out_sel_s[1]), .o_valid(valid_s[1]),
        .o_done(done_s[1]));

    int n_cmp = 0;
    int n_bad = 0;
    int lat[2] = '{1, 3};

    logic [7:0] frame [IR][W];
    logic [7:0] lbuf  [2][2][W];
    logic [7:0] p_orig[2][8];
    logic [7:0] p_int [2][8];

    int req_cnt[2], host_c[2], exp_req_n[2], exp_fv[2], out_idx[2], exp_done_n[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Edge-directed average: pick the direction with the smallest difference.
    function automatic logic [7:0] ela3(input logic [7:0] am, a0, ap, bm, b0, bp);
        int d1, d2, d3;
        d1 = int'(am) - int'(bp); if (d1 < 0) d1 = -d1;
        d2 = int'(a0) - int'(b0); if (d2 < 0) d2 = -d2;
        d3 = int'(ap) - int'(bm); if (d3 < 0) d3 = -d3;
        if (d2 <= d1 && d2 <= d3) return 8'((int'(a0) + int'(b0)) / 2);
        else if (d1 <= d3)        return 8'((int'(am) + int'(bp)) / 2);
        else                      return 8'((int'(ap) + int'(bm)) / 2);
    endfunction

    // Golden output pixel: even output rows are inputs, odd rows interpolate neighbours.
    function automatic logic [7:0] gold(input int orow, input int col);
        int ra, rb, cm, cp;
        cm = (col > 0) ? col - 1 : 0;
        cp = (col < W - 1) ? col + 1 : W - 1;
        if (orow % 2 == 0) return frame[orow / 2][col];
        ra = (orow - 1) / 2;
        rb = ra + 1;
        return ela3(frame[ra][cm], frame[ra][col], frame[ra][cp],
                    frame[rb][cm], frame[rb][col], frame[rb][cp]);
    endfunction

    task automatic new_frame();
        for (int r = 0; r < IR; r++)
            for (int c = 0; c < W; c++)
                frame[r][c] = 8'($urandom);
    endtask

    // One cycle of host + datapath model + checks for instance i, cycle n.
    task automatic mon(input int i, input int n);
        int j, hrow, rowlen, orow, col, cm, cp, t;
        bit exp_wr, exp_v;
        logic [7:0] pix, dat;
        if (n == 0)
            chk("reset_state",
                {req_s[i], wr_en_s[i], wr_buf_s[i], rd_top_s[i], out_sel_s[i], valid_s[i],
                 done_s[i], wr_addr_s[i], rd_addr_s[i]}, 32'd0);
        j = n - host_c[i] - 2;
        hrow = (req_cnt[i] > IR) ? IR - 1 : req_cnt[i] - 1;
        exp_wr = (req_cnt[i] > 0) && (j >= 0) && (j < W);
        pix = exp_wr ? frame[hrow][j] : 8'($urandom);
        chk("wr_en", wr_en_s[i], exp_wr);
        if (exp_wr) begin
            chk("wr_addr", wr_addr_s[i], j);
            chk("wr_buf", wr_buf_s[i], hrow % 2);
        end
        if (wr_en_s[i] === 1'b1) lbuf[i][wr_buf_s[i]][wr_addr_s[i]] = pix;
        chk("req", req_s[i], n == exp_req_n[i]);
        if (req_s[i] === 1'b1) begin
            req_cnt[i]++;
            host_c[i] = n;
            exp_fv[i] = n + W + 2 + lat[i];
        end
        for (int k = 7; k > 0; k--) begin
            p_orig[i][k] = p_orig[i][k-1];
            p_int[i][k]  = p_int[i][k-1];
        end
        t = int'(rd_top_s[i]);
        col = int'(rd_addr_s[i]);
        cm = (col > 0) ? col - 1 : 0;
        cp = (col < W - 1) ? col + 1 : W - 1;
        p_orig[i][0] = lbuf[i][t][col];
        p_int[i][0]  = ela3(lbuf[i][t][cm], lbuf[i][t][col], lbuf[i][t][cp],
                            lbuf[i][1-t][cm], lbuf[i][1-t][col], lbuf[i][1-t][cp]);
        rowlen = (req_cnt[i] <= 1) ? W : 2 * W;
        exp_v = (n >= exp_fv[i]) && (n < exp_fv[i] + rowlen);
        chk("valid", valid_s[i], exp_v);
        if (valid_s[i] === 1'b1 && out_idx[i] < NOUT) begin
            orow = out_idx[i] / W;
            chk("out_sel", out_sel_s[i], orow % 2);
            dat = (out_sel_s[i] === 1'b1) ? p_int[i][lat[i]] : p_orig[i][lat[i]];
            chk("out_data", dat, gold(orow, out_idx[i] % W));
            out_idx[i]++;
        end
        if (n == exp_fv[i] + rowlen - 1) begin
            if (req_cnt[i] < IR) exp_req_n[i] = n + 1;
            else                 exp_done_n[i] = n + 1;
        end
        chk("done", done_s[i], n >= exp_done_n[i]);
    endtask

    // Runs one frame from the cycle after a reset edge; optionally aborts early.
    task automatic run_frame(input int abort_at, output bit aborted);
        bit finished;
        finished = 1'b0;
        aborted  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_cnt[i] = 0; host_c[i] = -100; exp_req_n[i] = 1;
            exp_fv[i] = 1 << 30; out_idx[i] = 0; exp_done_n[i] = 1 << 30;
            for (int k = 0; k < 8; k++) begin p_orig[i][k] = 8'd0; p_int[i][k] = 8'd0; end
        end
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            mon(0, n);
            mon(1, n);
            if (abort_at >= 0 && out_idx[0] == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (n >= exp_done_n[0] + 20 && n >= exp_done_n[1] + 20) begin
                finished = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            chk("frame_end", finished, 1'b1);
            for (int i = 0; i < 2; i++) begin
                chk("valid_total", out_idx[i], NOUT);
                chk("req_total", req_cnt[i], IR);
            end
        end
    endtask

    initial begin
        bit ab;
        int abort_at;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk("rst_hold",
                {req_s[i], wr_en_s[i], valid_s[i], done_s[i], rd_addr_s[i]}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Full frame from power-up.
        new_frame();
        run_frame(-1, ab);

        // Restart, then abort in the middle of row 2's interpolated output.
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        new_frame();
        abort_at = 3 * W + $urandom_range(1, W - 2);
        run_frame(abort_at, ab);
        chk("abort_reached", ab, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // Frame after the abort must run completely from row 0.
        new_frame();
        run_frame(-1, ab);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
